// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selection and legal oversampling ratios.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
   parameter int prescale_width = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_s,
   input  logic [prescale_width-1:0] prescale,
   input  logic                      run,
   input  logic                      clear,
   output logic                      sampled_bit,
   output logic                      bit_done,
   output logic                      bit_end
);

   localparam logic [prescale_width-1:0] ONE = prescale_width'(1);
   localparam logic [prescale_width-1:0] TWO = prescale_width'(2);

   logic [prescale_width-1:0] edge_cnt_q, edge_cnt_d;
   logic [prescale_width-1:0] half;
   logic [2:0]                samples_q, samples_d;

   assign half        = prescale >> 1;
   assign sampled_bit = (samples_q[0] & samples_q[1]) |
                        (samples_q[0] & samples_q[2]) |
                        (samples_q[1] & samples_q[2]);

   // The decision edge sits one edge after the last sample so all three are registered.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      samples_d  = samples_q;
      bit_end    = (edge_cnt_q == prescale - ONE);
      bit_done   = (edge_cnt_q == half + TWO);
      if (edge_cnt_q == half - ONE) samples_d[0] = rx_s;
      if (edge_cnt_q == half)       samples_d[1] = rx_s;
      if (edge_cnt_q == half + ONE) samples_d[2] = rx_s;
      if (clear || !run) begin
         edge_cnt_d = '0;
      end else if (bit_end) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = edge_cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_q <= '0;
         samples_q  <= 3'b111;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         samples_q  <= samples_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: line synchronizer plus frame FSM; emits payload with one-cycle valid/error strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int data_width     = 8,
   parameter int prescale_width = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [prescale_width-1:0] Prescale,
   output logic [data_width-1:0]     P_DATA,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stp_err
);

   localparam int BIT_CNT_W = (data_width > 1) ? $clog2(data_width) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(data_width - 1);

   uart_state_e               state_q, state_d;
   logic [1:0]                sync_q, sync_d;
   logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [data_width-1:0]     shadow_q, shadow_d;
   logic [data_width-1:0]     p_data_q, p_data_d;
   logic [prescale_width-1:0] prescale_q, prescale_d;
   logic                      par_en_q, par_en_d;
   logic                      par_typ_q, par_typ_d;
   logic                      par_mis_q, par_mis_d;
   logic                      data_valid_q, data_valid_d;
   logic                      par_err_q, par_err_d;
   logic                      stp_err_q, stp_err_d;
   logic                      rx_s, run, clear;
   logic                      sampled_bit, bit_done, bit_end;

   assign rx_s       = sync_q[1];
   assign sync_d     = {sync_q[0], RX_IN};
   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

   uart_rx_sampler #(
      .prescale_width(prescale_width)
   ) u_sampler (
      .clk        (CLK),
      .rst_n      (RST),
      .rx_s       (rx_s),
      .prescale   (prescale_q),
      .run        (run),
      .clear      (clear),
      .sampled_bit(sampled_bit),
      .bit_done   (bit_done),
      .bit_end    (bit_end)
   );

   // Frame configuration is re-latched every idle cycle, so it is frozen from the start edge on.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shadow_d     = shadow_q;
      p_data_d     = p_data_q;
      prescale_d   = prescale_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_mis_d    = par_mis_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;
      run          = 1'b1;
      clear        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            prescale_d = Prescale;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            bit_cnt_d  = '0;
            run        = !rx_s;
            if (!rx_s) begin
               state_d   = ST_START;
               par_mis_d = 1'b0;
            end
         end
         ST_START: begin
            if (bit_done && sampled_bit) begin
               state_d = ST_IDLE;
               clear   = 1'b1;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done) shadow_d[bit_cnt_q] = sampled_bit;
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) par_mis_d = (sampled_bit != ((^shadow_q) ^ (par_typ_q == PAR_ODD)));
            if (bit_end)  state_d = ST_STOP;
         end
         ST_STOP: begin
            // Leave at the decision edge so a start bit right after the stop bit is not missed.
            if (bit_done) begin
               state_d      = ST_IDLE;
               clear        = 1'b1;
               stp_err_d    = !sampled_bit;
               par_err_d    = par_mis_q;
               data_valid_d = sampled_bit && !par_mis_q;
               if (data_valid_d) p_data_d = shadow_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            clear   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         sync_q       <= 2'b11;
         bit_cnt_q    <= '0;
         shadow_q     <= '0;
         p_data_q     <= '0;
         prescale_q   <= prescale_width'(PRESCALE_8);
         par_en_q     <= 1'b0;
         par_typ_q    <= PAR_EVEN;
         par_mis_q    <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         bit_cnt_q    <= bit_cnt_d;
         shadow_q     <= shadow_d;
         p_data_q     <= p_data_d;
         prescale_q   <= prescale_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_mis_q    <= par_mis_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner sequences, random frames.
module tb_uart_rx;
   import uart_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      int         presc;
      logic       flip_par;
      logic       stop_bit;
      int         gap;
      logic       exp_valid;
      logic       exp_perr;
      logic       exp_serr;
      logic [7:0] exp_pdata;
   } vec_t;

   typedef struct packed {
      logic       valid;
      logic       perr;
      logic       serr;
      logic [7:0] pdata;
   } evt_t;

   evt_t       exp_q[$];
   evt_t       obs_q[$];
   evt_t       mon_e;
   vec_t       table_v[7];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] model_pdata;

   uart_rx #(.data_width(8), .prescale_width(6)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .Prescale  (Prescale),
      .P_DATA    (P_DATA),
      .data_valid(data_valid),
      .par_err   (par_err),
      .stp_err   (stp_err)
   );

   always #5 CLK = ~CLK;

   // Every cycle with any strobe high becomes one observed event.
   always @(negedge CLK) begin
      if (RST && (data_valid || par_err || stp_err)) begin
         mon_e.valid = data_valid;
         mon_e.perr  = par_err;
         mon_e.serr  = stp_err;
         mon_e.pdata = P_DATA;
         obs_q.push_back(mon_e);
      end
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int pickPrescale();
      case ($urandom_range(0, 2))
         0:       return PRESCALE_8;
         1:       return PRESCALE_16;
         default: return PRESCALE_32;
      endcase
   endfunction

   task automatic driveBit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(negedge CLK);
   endtask

   // Configuration inputs are scrambled mid-frame; the receiver must ignore them.
   task automatic sendFrame(input vec_t v);
      PAR_EN   = v.par_en;
      PAR_TYP  = v.par_typ;
      Prescale = 6'(v.presc);
      driveBit(1'b0, v.presc);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
      Prescale = 6'(pickPrescale());
      for (int i = 0; i < 8; i++) driveBit(v.data[i], v.presc);
      PAR_EN   = v.par_en;
      PAR_TYP  = v.par_typ;
      Prescale = 6'(v.presc);
      if (v.par_en) driveBit((^v.data) ^ v.par_typ ^ v.flip_par, v.presc);
      driveBit(v.stop_bit, v.presc);
      RX_IN = 1'b1;
      repeat (v.gap) @(negedge CLK);
   endtask

   task automatic applyStimulus(input vec_t v);
      evt_t e;
      e.valid = v.exp_valid;
      e.perr  = v.exp_perr;
      e.serr  = v.exp_serr;
      e.pdata = v.exp_pdata;
      exp_q.push_back(e);
      sendFrame(v);
   endtask

   // Reference behaviour from frame rules: errors from injected faults, payload held on error.
   function automatic vec_t modelExpect(input vec_t v);
      vec_t r = v;
      r.exp_perr  = v.par_en && v.flip_par;
      r.exp_serr  = !v.stop_bit;
      r.exp_valid = !r.exp_perr && !r.exp_serr;
      if (r.exp_valid) model_pdata = v.data;
      r.exp_pdata = model_pdata;
      return r;
   endfunction

   task automatic drainCheck(input string tag);
      int n;
      repeat (40) @(negedge CLK);
      checkOutput({tag, " event count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s event %0d {valid,perr,serr,pdata}", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic measureLatency(input int expected_cycles);
      int  cyc = 0;
      bit  seen = 1'b0;
      while (!seen && cyc < 400) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (data_valid) seen = 1'b1;
      end
      checkOutput("frame latency (clocks)", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(expected_cycles));
   endtask

   initial begin
      vec_t v;

      table_v[0] = '{8'hA5, 1'b1, 1'b0,  8, 1'b0, 1'b1,  8, 1'b1, 1'b0, 1'b0, 8'hA5};
      table_v[1] = '{8'h0F, 1'b1, 1'b0,  8, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b0, 8'hA5};
      table_v[2] = '{8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1, 8'hA5};
      table_v[3] = '{8'h77, 1'b1, 1'b1,  8, 1'b1, 1'b0,  8, 1'b0, 1'b1, 1'b1, 8'hA5};
      table_v[4] = '{8'h01, 1'b1, 1'b1, 32, 1'b0, 1'b1,  0, 1'b1, 1'b0, 1'b0, 8'h01};
      table_v[5] = '{8'hFF, 1'b1, 1'b1, 32, 1'b0, 1'b1, 32, 1'b1, 1'b0, 1'b0, 8'hFF};
      table_v[6] = '{8'h96, 1'b0, 1'b1, 16, 1'b0, 1'b1,  0, 1'b1, 1'b0, 1'b0, 8'h96};

      repeat (3) @(negedge CLK);
      checkOutput("reset P_DATA", 32'(P_DATA), 32'h0);
      checkOutput("reset data_valid", 32'(data_valid), 32'h0);
      checkOutput("reset par_err", 32'(par_err), 32'h0);
      checkOutput("reset stp_err", 32'(stp_err), 32'h0);
      RST = 1'b1;
      repeat (5) @(negedge CLK);

      for (int i = 0; i < 7; i++) applyStimulus(table_v[i]);
      drainCheck("table");

      $display("[TB] start glitch then 0x55");
      Prescale = 6'd16;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (30) @(negedge CLK);
      applyStimulus('{8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h55});
      drainCheck("glitch");

      $display("[TB] latency, 8N1 at prescale 8");
      v = '{8'hC3, 1'b0, 1'b0, 8, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 8'hC3};
      fork
         applyStimulus(v);
         measureLatency(9 * 8 + 8 / 2 + 5);
      join
      drainCheck("latency");

      $display("[TB] reset during data bit 3");
      Prescale = 6'd16;
      PAR_EN   = 1'b0;
      driveBit(1'b0, 16);
      driveBit(1'b1, 16);
      driveBit(1'b0, 16);
      driveBit(1'b0, 16);
      RX_IN = 1'b0;
      repeat (8) @(negedge CLK);
      RST = 1'b0;
      #1;
      checkOutput("mid-frame reset P_DATA", 32'(P_DATA), 32'h0);
      checkOutput("mid-frame reset data_valid", 32'(data_valid), 32'h0);
      checkOutput("mid-frame reset par_err", 32'(par_err), 32'h0);
      checkOutput("mid-frame reset stp_err", 32'(stp_err), 32'h0);
      RX_IN = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (20) @(negedge CLK);
      applyStimulus('{8'h81, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h81});
      drainCheck("reset");

      $display("[TB] random frames");
      model_pdata = 8'h81;
      for (int k = 0; k < 30; k++) begin
         v.data     = 8'($urandom);
         v.par_en   = 1'($urandom);
         v.par_typ  = 1'($urandom);
         v.presc    = pickPrescale();
         v.flip_par = ($urandom_range(0, 3) == 0);
         v.stop_bit = ($urandom_range(0, 3) != 0);
         v.gap      = v.stop_bit ? int'($urandom_range(0, v.presc)) : v.presc;
         applyStimulus(modelExpect(v));
      end
      drainCheck("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
